// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: command encodings, default timings,
// page size and the idle values of the bank/address buses.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam int TRCD_DEF  = 2;
    localparam int TWR_DEF   = 2;
    localparam int TRP_DEF   = 2;
    localparam int PAGE_SIZE = 512;

    localparam logic [1:0]  IDLE_BANK = 2'b11;
    localparam logic [12:0] IDLE_ADDR = 13'h1fff;
    localparam logic [12:0] PRE_ADDR  = 13'h0400;

    // Final WRITE-state count for a requested burst length, clamped to 1..PAGE_SIZE.
    function automatic logic [9:0] burst_last(input logic [9:0] len);
        if (len == 10'd0)
            return 10'd0;
        else if (len > 10'(PAGE_SIZE))
            return 10'(PAGE_SIZE - 1);
        else
            return len - 10'd1;
    endfunction

endpackage

// File: rtl/sdram_write.sv
// Write-burst engine: ACT, full-page write burst, BST, write recovery, PRE.
// Optional byte masking is enabled by defining SDRAM_WR_MASK_EN.
module sdram_write
    import sdram_pkg::*;
#(
    parameter int TRCD = TRCD_DEF,
    parameter int TWR  = TWR_DEF,
    parameter int TRP  = TRP_DEF
) (
    input  logic        wr_clk,
    input  logic        wr_rst_n,
    input  logic        init_end,
    input  logic        wr_en,
    input  logic [23:0] wr_addr,
    input  logic [9:0]  wr_bst_len,
    input  logic [15:0] wr_data,
`ifdef SDRAM_WR_MASK_EN
    input  logic [1:0]  wr_mask,
    output logic [1:0]  wr_sdram_dqm,
`endif
    output logic        wr_ack,
    output logic        wr_end,
    output logic [3:0]  wr_sdram_cmd,
    output logic [1:0]  wr_sdram_bank,
    output logic [12:0] wr_sdram_addr,
    output logic [15:0] wr_sdram_data,
    output logic        wr_sdram_en
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_TRCD, S_WRITE, S_BST, S_TWR, S_PRE, S_TRP, S_END
    } state_t;

    state_t     state;
    logic [9:0] cnt;
    logic [9:0] last;

    assign last   = burst_last(wr_bst_len);
    assign wr_ack = (state == S_WRITE);
    assign wr_end = (state == S_END);

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state         <= S_IDLE;
            cnt           <= 10'd0;
            wr_sdram_cmd  <= CMD_NOP;
            wr_sdram_bank <= IDLE_BANK;
            wr_sdram_addr <= IDLE_ADDR;
            wr_sdram_data <= 16'h0;
            wr_sdram_en   <= 1'b0;
`ifdef SDRAM_WR_MASK_EN
            wr_sdram_dqm  <= 2'b11;
`endif
        end else begin
            cnt <= cnt + 10'd1;
            case (state)
                S_IDLE: begin
                    cnt <= 10'd0;
                    if (init_end && wr_en) state <= S_ACT;
                end
                S_ACT: begin
                    state <= S_TRCD;
                    cnt   <= 10'd0;
                end
                S_TRCD: if (cnt == 10'(TRCD - 1)) begin
                    state <= S_WRITE;
                    cnt   <= 10'd0;
                end
                S_WRITE: if (cnt == last) begin
                    state <= S_BST;
                    cnt   <= 10'd0;
                end
                S_BST: begin
                    state <= S_TWR;
                    cnt   <= 10'd0;
                end
                S_TWR: if (cnt == 10'(TWR - 1)) begin
                    state <= S_PRE;
                    cnt   <= 10'd0;
                end
                S_PRE: begin
                    state <= S_TRP;
                    cnt   <= 10'd0;
                end
                S_TRP: if (cnt == 10'(TRP - 1)) begin
                    state <= S_END;
                    cnt   <= 10'd0;
                end
                // A request still pending at END chains straight into the next ACT.
                S_END: begin
                    state <= (init_end && wr_en) ? S_ACT : S_IDLE;
                    cnt   <= 10'd0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 10'd0;
                end
            endcase

            wr_sdram_cmd  <= CMD_NOP;
            wr_sdram_bank <= IDLE_BANK;
            wr_sdram_addr <= IDLE_ADDR;
            wr_sdram_en   <= 1'b0;
`ifdef SDRAM_WR_MASK_EN
            wr_sdram_dqm  <= 2'b11;
`endif
            case (state)
                S_ACT: begin
                    wr_sdram_cmd  <= CMD_ACT;
                    wr_sdram_bank <= wr_addr[23:22];
                    wr_sdram_addr <= wr_addr[21:9];
                end
                S_WRITE: begin
                    if (cnt == 10'd0) begin
                        wr_sdram_cmd  <= CMD_WR;
                        wr_sdram_bank <= wr_addr[23:22];
                        wr_sdram_addr <= {4'b0, wr_addr[8:0]};
                    end
                    wr_sdram_data <= wr_data;
                    wr_sdram_en   <= 1'b1;
`ifdef SDRAM_WR_MASK_EN
                    wr_sdram_dqm  <= wr_mask;
`endif
                end
                S_BST: wr_sdram_cmd <= CMD_BST;
                S_PRE: begin
                    wr_sdram_cmd  <= CMD_PRE;
                    wr_sdram_bank <= wr_addr[23:22];
                    wr_sdram_addr <= PRE_ADDR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: vector table of bursts plus hand-written
// sequences for idle gating, mid-burst reset and back-to-back requests.
module tb_sdram_write;
    import sdram_pkg::*;

    localparam int TRCD = 2;
    localparam int TWR  = 2;
    localparam int TRP  = 2;

    logic        wr_clk = 1'b0;
    logic        wr_rst_n, init_end, wr_en;
    logic [23:0] wr_addr;
    logic [9:0]  wr_bst_len;
    logic [15:0] wr_data;
    logic        wr_ack, wr_end, wr_sdram_en;
    logic [3:0]  wr_sdram_cmd;
    logic [1:0]  wr_sdram_bank;
    logic [12:0] wr_sdram_addr;
    logic [15:0] wr_sdram_data;
`ifdef SDRAM_WR_MASK_EN
    logic [1:0]  wr_mask;
    logic [1:0]  wr_sdram_dqm;
`endif

    sdram_write #(.TRCD(TRCD), .TWR(TWR), .TRP(TRP)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .init_end(init_end), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_bst_len(wr_bst_len), .wr_data(wr_data),
`ifdef SDRAM_WR_MASK_EN
        .wr_mask(wr_mask), .wr_sdram_dqm(wr_sdram_dqm),
`endif
        .wr_ack(wr_ack), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
        .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
        .wr_sdram_data(wr_sdram_data), .wr_sdram_en(wr_sdram_en)
    );

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [9:0]  len;
        int          exp_l;
        logic [15:0] base;
    } vec_t;

    // Per-transaction bus record, bus-cycle indices counted from the request.
    int act_cnt, act_cyc, wr_cyc, bst_cyc, pre_cyc, end_cnt, end_cyc;
    int ack_cnt, dq_cnt, dq_first, dq_last, dq_bad, dqm_bad;
    logic [14:0] act_bus, wr_bus, pre_bus;
    logic [15:0] col_mem [512];
    logic        col_wr  [512];

    task automatic run_txn(input logic [23:0] a, input logic [9:0] len, input logic [15:0] base);
        int k;
        logic [8:0] col;
        act_cnt = 0; act_cyc = -1; wr_cyc = -1; bst_cyc = -1; pre_cyc = -1;
        end_cnt = 0; end_cyc = -1; ack_cnt = 0; dq_cnt = 0; dq_first = -1;
        dq_last = -1; dq_bad = 0; dqm_bad = 0; act_bus = '0; wr_bus = '0; pre_bus = '0;
        for (int i = 0; i < 512; i++) col_wr[i] = 1'b0;
        k = 0;
        wr_addr = a; wr_bst_len = len; init_end = 1'b1; wr_en = 1'b1; wr_data = 16'h0;
        for (int c = 1; c <= 800; c++) begin
            @(posedge wr_clk); #1;
            if (c == 1) wr_en = 1'b0;
            if (wr_sdram_cmd == CMD_ACT) begin
                act_cnt++;
                if (act_cyc < 0) begin act_cyc = c; act_bus = {wr_sdram_bank, wr_sdram_addr}; end
            end
            if (wr_sdram_cmd == CMD_WR && wr_cyc < 0) begin
                wr_cyc = c; wr_bus = {wr_sdram_bank, wr_sdram_addr};
            end
            if (wr_sdram_cmd == CMD_BST) bst_cyc = c;
            if (wr_sdram_cmd == CMD_PRE) begin pre_cyc = c; pre_bus = {wr_sdram_bank, wr_sdram_addr}; end
            if (wr_sdram_en) begin
                if (dq_first < 0) dq_first = c;
                dq_last = c;
                if (wr_sdram_data !== base + 16'(dq_cnt)) dq_bad++;
                col = a[8:0] + 9'(dq_cnt);
                col_mem[col] = wr_sdram_data;
                col_wr[col]  = 1'b1;
`ifdef SDRAM_WR_MASK_EN
                if (wr_sdram_dqm !== ((dq_cnt == 2) ? 2'b01 : 2'b00)) dqm_bad++;
`endif
                dq_cnt++;
            end
`ifdef SDRAM_WR_MASK_EN
            else if (wr_sdram_dqm !== 2'b11) dqm_bad++;
`endif
            if (wr_ack) begin
                wr_data = base + 16'(k);
`ifdef SDRAM_WR_MASK_EN
                wr_mask = (k == 2) ? 2'b01 : 2'b00;
`endif
                k++;
                ack_cnt++;
            end
            if (wr_end) begin
                end_cnt++; end_cyc = c;
                break;
            end
        end
        repeat (3) @(posedge wr_clk);
        #1;
    endtask

    vec_t vecs[5];
    int   bad;
    int   b2b_end[3];
    int   b2b_act[3];
    int   ne, na;

    initial begin
        vecs[0] = '{24'hC0_2A05, 10'd10,  10,  16'h1000};
        vecs[1] = '{24'h41_2300, 10'd0,   1,   16'h2000};
        vecs[2] = '{24'h80_0000, 10'd600, 512, 16'h3000};
        vecs[3] = '{24'h00_01FE, 10'd4,   4,   16'h4000};
        vecs[4] = '{24'hFF_FFFF, 10'd1,   1,   16'h5000};

        wr_rst_n = 1'b0; init_end = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_bst_len = '0; wr_data = '0;
`ifdef SDRAM_WR_MASK_EN
        wr_mask = 2'b00;
`endif
        repeat (2) @(posedge wr_clk);
        #1;
        check("rst_cmd", 32'(wr_sdram_cmd), 32'(CMD_NOP));
        check("rst_bank_addr", 32'({wr_sdram_bank, wr_sdram_addr}), 32'h7fff);
        check("rst_data_en", 32'({wr_sdram_data, wr_sdram_en}), 32'h0);
        check("rst_ack_end", 32'({wr_ack, wr_end}), 32'h0);
`ifdef SDRAM_WR_MASK_EN
        check("rst_dqm", 32'(wr_sdram_dqm), 32'h3);
`endif
        wr_rst_n = 1'b1;

        // Request with init_end low must be ignored.
        wr_en = 1'b1; wr_bst_len = 10'd4; bad = 0;
        repeat (20) begin
            @(posedge wr_clk); #1;
            if (wr_sdram_cmd !== CMD_NOP || wr_ack !== 1'b0) bad++;
        end
        check("idle_no_init", 32'(bad), 32'h0);
        wr_en = 1'b0;
        @(posedge wr_clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].addr, vecs[i].len, vecs[i].base);
            check($sformatf("v%0d_act_cyc", i), 32'(act_cyc), 32'd2);
            check($sformatf("v%0d_act_bus", i), 32'(act_bus), 32'({vecs[i].addr[23:22], vecs[i].addr[21:9]}));
            check($sformatf("v%0d_act_cnt", i), 32'(act_cnt), 32'd1);
            check($sformatf("v%0d_wr_cyc", i), 32'(wr_cyc), 32'(TRCD + 3));
            check($sformatf("v%0d_wr_bus", i), 32'(wr_bus), 32'({vecs[i].addr[23:22], 4'b0, vecs[i].addr[8:0]}));
            check($sformatf("v%0d_acks", i), 32'(ack_cnt), 32'(vecs[i].exp_l));
            check($sformatf("v%0d_dq_cnt", i), 32'(dq_cnt), 32'(vecs[i].exp_l));
            check($sformatf("v%0d_dq_first", i), 32'(dq_first), 32'(TRCD + 3));
            check($sformatf("v%0d_dq_data", i), 32'(dq_bad), 32'h0);
            check($sformatf("v%0d_bst_cyc", i), 32'(bst_cyc), 32'(dq_last + 1));
            check($sformatf("v%0d_pre_cyc", i), 32'(pre_cyc), 32'(TRCD + 3 + vecs[i].exp_l + TWR + 1));
            check($sformatf("v%0d_pre_bus", i), 32'(pre_bus), 32'({vecs[i].addr[23:22], 13'h0400}));
            check($sformatf("v%0d_end_cnt", i), 32'(end_cnt), 32'd1);
            check($sformatf("v%0d_end_cyc", i), 32'(end_cyc), 32'(pre_cyc + TRP));
`ifdef SDRAM_WR_MASK_EN
            check($sformatf("v%0d_dqm", i), 32'(dqm_bad), 32'h0);
`endif
            if (i == 3) begin
                check("wrap_1fe", 32'({col_wr[9'h1fe], col_mem[9'h1fe]}), 32'h14000);
                check("wrap_1ff", 32'({col_wr[9'h1ff], col_mem[9'h1ff]}), 32'h14001);
                check("wrap_000", 32'({col_wr[9'h000], col_mem[9'h000]}), 32'h14002);
                check("wrap_001", 32'({col_wr[9'h001], col_mem[9'h001]}), 32'h14003);
                check("wrap_002_clean", 32'(col_wr[9'h002]), 32'h0);
            end
        end

        // Reset asserted in the middle of a WRITE burst.
        wr_addr = 24'h40_0010; wr_bst_len = 10'd20; wr_en = 1'b1; init_end = 1'b1; bad = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge wr_clk); #1;
            wr_en = 1'b0;
            if (wr_ack) begin bad = 0; break; end
        end
        check("mid_reach_write", 32'(bad), 32'h0);
        repeat (3) @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b0;
        @(posedge wr_clk); #1;
        check("mid_rst_cmd", 32'(wr_sdram_cmd), 32'(CMD_NOP));
        check("mid_rst_bank_addr", 32'({wr_sdram_bank, wr_sdram_addr}), 32'h7fff);
        check("mid_rst_data_en", 32'({wr_sdram_data, wr_sdram_en}), 32'h0);
        check("mid_rst_ack_end", 32'({wr_ack, wr_end}), 32'h0);
        wr_rst_n = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;

        // Back-to-back: wr_en held through three transactions.
        wr_addr = 24'h81_0020; wr_bst_len = 10'd2; wr_en = 1'b1; ne = 0; na = 0;
        for (int c = 1; c <= 300 && ne < 3; c++) begin
            @(posedge wr_clk); #1;
            if (wr_sdram_cmd == CMD_ACT && na < 3) begin b2b_act[na] = c; na++; end
            if (wr_end) begin
                b2b_end[ne] = c; ne++;
                if (ne == 3) wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("b2b_ends", 32'(ne), 32'd3);
        check("b2b_acts", 32'(na), 32'd3);
        if (ne == 3 && na == 3) begin
            check("b2b_act1_gap", 32'(b2b_act[1] - b2b_end[0]), 32'd2);
            check("b2b_act2_gap", 32'(b2b_act[2] - b2b_end[1]), 32'd2);
        end
        bad = 0;
        repeat (10) begin
            @(posedge wr_clk); #1;
            if (wr_sdram_cmd !== CMD_NOP || wr_ack || wr_end) bad++;
        end
        check("b2b_quiet_after", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
